// File: rtl/laser310_clk_pkg.sv
// Shared types and divide constants for the Laser 310 clock-enable / reset sequencer.
package laser310_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TURBO_X1   = 2'b00,
        TURBO_X2   = 2'b01,
        TURBO_X4   = 2'b10,
        TURBO_RSVD = 2'b11
    } turbo_e;

    localparam int unsigned DIV_W   = 4;
    localparam int unsigned DIV_X1  = 12;
    localparam int unsigned DIV_X2  = 6;
    localparam int unsigned DIV_X4  = 3;
    localparam int unsigned DIV_VDP = 12;

    // Reserved turbo code runs at the base rate.
    function automatic logic [DIV_W-1:0] turbo_div(input logic [1:0] turbo);
        case (turbo_e'(turbo))
            TURBO_X2: return DIV_W'(DIV_X2);
            TURBO_X4: return DIV_W'(DIV_X4);
            default:  return DIV_W'(DIV_X1);
        endcase
    endfunction

endpackage

// File: rtl/laser310_clk_sync2.sv
// Generic two-flop synchronizer, asynchronously cleared to zero.
module laser310_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/laser310_clk_ctrl.sv
// PLL-lock reset sequencer plus CPU (turbo/pause) and video clock-enable generators.
module laser310_clk_ctrl
    import laser310_clk_pkg::*;
#(
    parameter int unsigned LOCK_DELAY = 4096,
    parameter int unsigned CNT_W      = 13
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic [1:0] turbo_i,
    input  logic       pause_i,
    output logic       sys_rst_o,
    output logic       ce_cpu_o,
    output logic       ce_cpu_n_o,
    output logic       ce_vdp_o
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_DELAY - 1);
    localparam logic [DIV_W-1:0] VDP_LAST  = DIV_W'(DIV_VDP - 1);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [DIV_W-1:0] cpu_cnt_q, cpu_cnt_d;
    logic [DIV_W-1:0] vdp_cnt_q, vdp_cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic             sys_rst_q, ce_cpu_q, ce_cpu_n_q, ce_vdp_q;
    logic             ce_cpu_d, ce_cpu_n_d, ce_vdp_d;
    logic             stay_run, cpu_wrap, cpu_mid, vdp_wrap;

    laser310_sync2 #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pll_locked_i),
        .q_o  (locked_s)
    );

    always_comb begin
        state_d = state_q;
        stab_d  = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s)               state_d = WAIT_LOCK;
                else if (stab_q == STAB_LAST) state_d = RUN;
                else                          stab_d  = stab_q + 1'b1;
            end
            RUN: begin
                if (!locked_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Dividers only advance while staying in RUN, so leaving RUN clears them on the same edge.
    assign stay_run = (state_q == RUN) && (state_d == RUN);
    assign cpu_wrap = cpu_cnt_q == (div_act_q - ONE);
    assign cpu_mid  = cpu_cnt_q == ((div_act_q >> 1) - ONE);
    assign vdp_wrap = vdp_cnt_q == VDP_LAST;

    always_comb begin
        cpu_cnt_d  = '0;
        vdp_cnt_d  = '0;
        div_act_d  = div_act_q;
        ce_cpu_d   = 1'b0;
        ce_cpu_n_d = 1'b0;
        ce_vdp_d   = 1'b0;
        if (stay_run) begin
            cpu_cnt_d  = cpu_wrap ? '0 : cpu_cnt_q + ONE;
            vdp_cnt_d  = vdp_wrap ? '0 : vdp_cnt_q + ONE;
            // New divide only at a period boundary so no period is truncated.
            if (cpu_wrap) div_act_d = turbo_div(turbo_i);
            ce_cpu_d   = cpu_wrap && !pause_i;
            ce_cpu_n_d = cpu_mid && !pause_i;
            ce_vdp_d   = vdp_wrap;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= WAIT_LOCK;
            stab_q     <= '0;
            cpu_cnt_q  <= '0;
            vdp_cnt_q  <= '0;
            div_act_q  <= DIV_W'(DIV_X1);
            sys_rst_q  <= 1'b1;
            ce_cpu_q   <= 1'b0;
            ce_cpu_n_q <= 1'b0;
            ce_vdp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_q     <= stab_d;
            cpu_cnt_q  <= cpu_cnt_d;
            vdp_cnt_q  <= vdp_cnt_d;
            div_act_q  <= div_act_d;
            sys_rst_q  <= (state_d != RUN);
            ce_cpu_q   <= ce_cpu_d;
            ce_cpu_n_q <= ce_cpu_n_d;
            ce_vdp_q   <= ce_vdp_d;
        end
    end

    assign sys_rst_o  = sys_rst_q;
    assign ce_cpu_o   = ce_cpu_q;
    assign ce_cpu_n_o = ce_cpu_n_q;
    assign ce_vdp_o   = ce_vdp_q;

endmodule

// File: tb/tb_laser310_clk_ctrl.sv
// Scoreboard bench: expected edge numbers of each output event are queued ahead of time.
module tb_laser310_clk_ctrl;

    localparam int unsigned LD = 16;
    localparam int K_FALL = 0, K_RISE = 1, K_CPU = 2, K_CPUN = 3, K_VDP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic [1:0] turbo;
    logic       pause;
    logic       sys_rst, ce_cpu, ce_cpu_n, ce_vdp;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int q [5][$];
    bit   mon_en   = 1'b0;
    logic rst_prev = 1'b1;

    laser310_clk_ctrl #(
        .LOCK_DELAY(LD),
        .CNT_W     (5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pll_locked_i(pll_locked),
        .turbo_i     (turbo),
        .pause_i     (pause),
        .sys_rst_o   (sys_rst),
        .ce_cpu_o    (ce_cpu),
        .ce_cpu_n_o  (ce_cpu_n),
        .ce_vdp_o    (ce_vdp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_FALL:  return "sys_rst_fall";
            K_RISE:  return "sys_rst_rise";
            K_CPU:   return "ce_cpu";
            K_CPUN:  return "ce_cpu_n";
            default: return "ce_vdp";
        endcase
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b, want %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int k);
        checks++;
        if (q[k].size() != 0 && q[k][0] == cyc) begin
            void'(q[k].pop_front());
        end else begin
            failures++;
            if (q[k].size() == 0)
                $display("FAIL %s: got pulse at cycle %0d, want none", kname(k), cyc);
            else
                $display("FAIL %s: got pulse at cycle %0d, want next at %0d", kname(k), cyc,
                         q[k][0]);
        end
    endtask

    // Monitor: retire overdue expectations, then match every observed event.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 5; k++) begin
                while (q[k].size() != 0 && q[k][0] < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: got no pulse, want pulse at cycle %0d", kname(k), q[k][0]);
                    void'(q[k].pop_front());
                end
            end
            if (sys_rst && !rst_prev) observe(K_RISE);
            if (!sys_rst && rst_prev) observe(K_FALL);
            if (ce_cpu)   observe(K_CPU);
            if (ce_cpu_n) observe(K_CPUN);
            if (ce_vdp)   observe(K_VDP);
            rst_prev <= sys_rst;
        end
    end

    // Periods of divide d starting at edge s: ce_cpu_n at s+d/2, ce_cpu at s+d.
    // Edges inside [lo, hi] are suppressed by pause.
    task automatic push_cpu(input int s, input int d, input int n, input int lo, input int hi,
                            output int s_o);
        int t;
        t = s;
        for (int i = 0; i < n; i++) begin
            if (t + d / 2 < lo || t + d / 2 > hi) q[K_CPUN].push_back(t + d / 2);
            if (t + d < lo || t + d > hi)         q[K_CPU].push_back(t + d);
            t += d;
        end
        s_o = t;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int r, s, n2, r2, m, r3;
        rst = 1'b1; pll_locked = 1'b0; turbo = 2'b00; pause = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset_sys_rst", sys_rst, 1'b1);
        check_bit("reset_ce_cpu", ce_cpu, 1'b0);
        check_bit("reset_ce_cpu_n", ce_cpu_n, 1'b0);
        check_bit("reset_ce_vdp", ce_vdp, 1'b0);
        mon_en = 1'b1;
        rst = 1'b0;

        // No lock for 100 cycles: any event is flagged by the monitor.
        wait_until(cyc + 100);
        check_bit("nolock_sys_rst", sys_rst, 1'b1);

        // Lock: first sampling edge is cyc+1, release 18 edges after it.
        r = cyc + 19;
        q[K_FALL].push_back(r);
        for (int k = 1; k <= 14; k++) q[K_VDP].push_back(r + 12 * k);
        push_cpu(r, 12, 4, 0, -1, s);          // turbo 01 set at cnt 4 of 4th period
        push_cpu(s, 6, 4, 0, -1, s);           // turbo 10 set in last x2 period
        push_cpu(s, 3, 6, 0, -1, s);           // turbo 11 set in last x4 period
        push_cpu(s, 12, 7, r + 129, r + 158, s);
        q[K_RISE].push_back(r + 180);
        pll_locked = 1'b1;

        wait_until(r + 40);  turbo = 2'b01;
        wait_until(r + 68);  turbo = 2'b10;
        wait_until(r + 88);  turbo = 2'b11;
        wait_until(r + 128); pause = 1'b1;
        wait_until(r + 158); pause = 1'b0;
        wait_until(r + 177); pll_locked = 1'b0;
        wait_until(r + 180);
        check_bit("lockloss_sys_rst", sys_rst, 1'b1);
        check_bit("lockloss_ce_cpu", ce_cpu, 1'b0);
        check_bit("lockloss_ce_cpu_n", ce_cpu_n, 1'b0);
        check_bit("lockloss_ce_vdp", ce_vdp, 1'b0);

        // Re-lock with a one-sample glitch at stable count ~10.
        wait_until(r + 185);
        n2 = cyc;
        r2 = n2 + 32;
        q[K_FALL].push_back(r2);
        push_cpu(r2, 12, 2, 0, -1, s);
        q[K_VDP].push_back(r2 + 12);
        q[K_VDP].push_back(r2 + 24);
        q[K_RISE].push_back(r2 + 25);
        pll_locked = 1'b1;
        wait_until(n2 + 12); pll_locked = 1'b0;
        wait_until(n2 + 13); pll_locked = 1'b1;

        // Async reset while ce_cpu and ce_vdp are high.
        wait_until(r2 + 24);
        #3 rst = 1'b1;
        #1;
        check_bit("async_sys_rst", sys_rst, 1'b1);
        check_bit("async_ce_cpu", ce_cpu, 1'b0);
        check_bit("async_ce_cpu_n", ce_cpu_n, 1'b0);
        check_bit("async_ce_vdp", ce_vdp, 1'b0);

        // Release: full lock sequence again; divide restarts at 12 despite turbo 01.
        wait_until(r2 + 27);
        m  = cyc;
        r3 = m + 19;
        q[K_FALL].push_back(r3);
        push_cpu(r3, 12, 1, 0, -1, s);
        push_cpu(s, 6, 3, 0, -1, s);
        q[K_VDP].push_back(r3 + 12);
        q[K_VDP].push_back(r3 + 24);
        turbo = 2'b01;
        rst = 1'b0;
        wait_until(r3 + 31);

        mon_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                failures++;
                $display("FAIL %s_leftover: got %0d pending, want 0", kname(k), q[k].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
